control_sequencer: RTL and testbench

Hardwired control unit that replaces hand-scripted T-state stimulus with a clocked step sequencer. It fetches an instruction through the existing datapath control strobes (PCout, MARin, IncPC, Zin, …) and decodes IR. It then drives the per-step execute strobes for ld, ldi, st, addi, the R-type ALU ops, nop and halt. It sits beside the Datapath and owns every control input the Datapath exposes.

---
 rtl/ctrl_pkg.sv | 65 ++++++
 rtl/ctrl_decode.sv | 98 +++++++++
 rtl/control_sequencer.sv | 122 ++++++++++++
 tb/tb_control_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALU codes, state encoding and control word
// for the control_sequencer hardwired control unit.
package ctrl_pkg;

  localparam int OPC_W   = 5;
  localparam int ALUOP_W = 4;

  localparam logic [OPC_W-1:0] OP_LD   = 5'd0;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OPC_W-1:0] OP_ST   = 5'd2;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd5;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd6;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd7;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'd16;
  localparam logic [OPC_W-1:0] OP_HALT = 5'd31;

  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3,
    S_T4, S_T5, S_T6, S_T7,
    S_STOPPED, S_HALTED
  } state_t;

  typedef struct packed {
    logic pcout;
    logic zlowout;
    logic zhighout;
    logic mdrout;
    logic marin;
    logic zin;
    logic pcin;
    logic mdrin;
    logic irin;
    logic yin;
    logic incpc;
    logic read;
    logic write;
    logic gra;
    logic grb;
    logic grc;
    logic rin;
    logic rout;
    logic baout;
    logic cout;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_word_t;

  function automatic logic [ALUOP_W-1:0] alu_code(
    input logic [OPC_W-1:0] opc
  );
    case (opc)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore decode of (state, opcode) into the Datapath control word.
// Pure combinational; reset gating lives in the top level.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  state_t             state,
  input  logic [OPC_W-1:0]   opcode,
  output ctrl_word_t         cw
);

  logic is_ld, is_ldi, is_st, is_addi, is_alu;
  logic base_imm, imm_op;

  assign is_ld    = (opcode == OP_LD);
  assign is_ldi   = (opcode == OP_LDI);
  assign is_st    = (opcode == OP_ST);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_alu   = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  // ld/st/ldi form Y from BAout, addi from the register itself
  assign base_imm = is_ld | is_st | is_ldi;
  assign imm_op   = base_imm | is_addi;

  always_comb begin
    cw        = '0;
    cw.alu_op = ALU_ADD;
    unique case (state)
      S_T0: begin
        cw.pcout = 1'b1;
        cw.marin = 1'b1;
        cw.incpc = 1'b1;
        cw.zin   = 1'b1;
      end
      S_T1: begin
        cw.zlowout = 1'b1;
        cw.pcin    = 1'b1;
        cw.read    = 1'b1;
        cw.mdrin   = 1'b1;
      end
      S_T2: begin
        cw.mdrout = 1'b1;
        cw.irin   = 1'b1;
      end
      S_T3: begin
        if (base_imm) begin
          cw.grb   = 1'b1;
          cw.baout = 1'b1;
          cw.yin   = 1'b1;
        end else if (is_addi || is_alu) begin
          cw.grb  = 1'b1;
          cw.rout = 1'b1;
          cw.yin  = 1'b1;
        end
      end
      S_T4: begin
        if (imm_op) begin
          cw.cout = 1'b1;
          cw.zin  = 1'b1;
        end else if (is_alu) begin
          cw.grc    = 1'b1;
          cw.rout   = 1'b1;
          cw.zin    = 1'b1;
          cw.alu_op = alu_code(opcode);
        end
      end
      S_T5: begin
        if (is_ld || is_st) begin
          cw.zlowout = 1'b1;
          cw.marin   = 1'b1;
        end else if (is_ldi || is_addi || is_alu) begin
          cw.zlowout = 1'b1;
          cw.gra     = 1'b1;
          cw.rin     = 1'b1;
        end
      end
      S_T6: begin
        if (is_ld) begin
          cw.read  = 1'b1;
          cw.mdrin = 1'b1;
        end else if (is_st) begin
          cw.gra   = 1'b1;
          cw.rout  = 1'b1;
          cw.mdrin = 1'b1;
        end
      end
      S_T7: begin
        if (is_ld) begin
          cw.mdrout = 1'b1;
          cw.gra    = 1'b1;
          cw.rin    = 1'b1;
        end else if (is_st) begin
          cw.write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control sequencer for the Datapath.
// Define CTRL_MEMWAIT_EN to stall T1, ld-T6 and st-T7 on Mem_ready.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int IR_W = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [IR_W-1:0]    IR,
  input  logic               Stop,
  input  logic               Mem_ready,
  output logic               PCout,
  output logic               Zlowout,
  output logic               Zhighout,
  output logic               MDRout,
  output logic               MARin,
  output logic               Zin,
  output logic               PCin,
  output logic               MDRin,
  output logic               IRin,
  output logic               Yin,
  output logic               IncPC,
  output logic               Read,
  output logic               Write,
  output logic               Gra,
  output logic               Grb,
  output logic               Grc,
  output logic               Rin,
  output logic               Rout,
  output logic               BAout,
  output logic               Cout,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               Run
);

  state_t           state, state_nxt;
  logic [OPC_W-1:0] opcode;
  logic             mem_ok;
  logic             ir_unused;
  ctrl_word_t       cw, cw_g;

  assign opcode    = IR[IR_W-1 -: OPC_W];
  assign ir_unused = ^IR[IR_W-OPC_W-1:0];

`ifdef CTRL_MEMWAIT_EN
  assign mem_ok = Mem_ready;
`else
  logic mem_unused;
  assign mem_ok     = 1'b1;
  assign mem_unused = Mem_ready;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_T0;
    else       state <= state_nxt;
  end

  logic   is_ld, is_st, has_exec, multi;
  state_t boundary;

  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign has_exec = (opcode <= OP_ADDI);
  assign multi    = is_ld | is_st;
  assign boundary = Stop ? S_STOPPED : S_T0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_T0: state_nxt = S_T1;
      S_T1: if (mem_ok) state_nxt = S_T2;
      S_T2: begin
        // halt beats a pending Stop on the same boundary
        if (opcode == OP_HALT) state_nxt = S_HALTED;
        else if (has_exec)     state_nxt = S_T3;
        else                   state_nxt = boundary;
      end
      S_T3: state_nxt = S_T4;
      S_T4: state_nxt = S_T5;
      S_T5: state_nxt = multi ? S_T6 : boundary;
      S_T6: if (!is_ld || mem_ok) state_nxt = S_T7;
      S_T7: if (!is_st || mem_ok) state_nxt = boundary;
      S_STOPPED: if (!Stop) state_nxt = S_T0;
      S_HALTED:  state_nxt = S_HALTED;
      default:   state_nxt = S_T0;
    endcase
  end

  ctrl_decode u_decode (
    .state  (state),
    .opcode (opcode),
    .cw     (cw)
  );

  always_comb begin
    cw_g     = Reset ? '0 : cw;
    PCout    = cw_g.pcout;
    Zlowout  = cw_g.zlowout;
    Zhighout = cw_g.zhighout;
    MDRout   = cw_g.mdrout;
    MARin    = cw_g.marin;
    Zin      = cw_g.zin;
    PCin     = cw_g.pcin;
    MDRin    = cw_g.mdrin;
    IRin     = cw_g.irin;
    Yin      = cw_g.yin;
    IncPC    = cw_g.incpc;
    Read     = cw_g.read;
    Write    = cw_g.write;
    Gra      = cw_g.gra;
    Grb      = cw_g.grb;
    Grc      = cw_g.grc;
    Rin      = cw_g.rin;
    Rout     = cw_g.rout;
    BAout    = cw_g.baout;
    Cout     = cw_g.cout;
    alu_op   = cw_g.alu_op;
    Run      = !Reset && (state != S_STOPPED) && (state != S_HALTED);
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer against a
// per-instruction strobe-table model.
module tb_control_sequencer;
  import ctrl_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Stop = 1'b0;
  logic        Mem_ready = 1'b1;
  logic [31:0] IR = '0;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin;
  logic IRin, Yin, IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout;
  logic BAout, Cout, Run;
  logic [3:0] alu_op;

  int n_chk = 0;
  int n_pass = 0;

  always #5 Clock = ~Clock;

  control_sequencer #(.IR_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Stop(Stop),
    .Mem_ready(Mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .MDRout(MDRout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC),
    .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .alu_op(alu_op), .Run(Run)
  );

  logic [19:0] obs;
  assign obs = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin,
                MDRin, IRin, Yin, IncPC, Read, Write, Gra, Grb, Grc,
                Rin, Rout, BAout, Cout};

  localparam logic [19:0] B_PCOUT  = 20'h80000;
  localparam logic [19:0] B_ZLO    = 20'h40000;
  localparam logic [19:0] B_MDROUT = 20'h10000;
  localparam logic [19:0] B_MARIN  = 20'h08000;
  localparam logic [19:0] B_ZIN    = 20'h04000;
  localparam logic [19:0] B_PCIN   = 20'h02000;
  localparam logic [19:0] B_MDRIN  = 20'h01000;
  localparam logic [19:0] B_IRIN   = 20'h00800;
  localparam logic [19:0] B_YIN    = 20'h00400;
  localparam logic [19:0] B_INC    = 20'h00200;
  localparam logic [19:0] B_READ   = 20'h00100;
  localparam logic [19:0] B_WRITE  = 20'h00080;
  localparam logic [19:0] B_GRA    = 20'h00040;
  localparam logic [19:0] B_GRB    = 20'h00020;
  localparam logic [19:0] B_GRC    = 20'h00010;
  localparam logic [19:0] B_RIN    = 20'h00008;
  localparam logic [19:0] B_ROUT   = 20'h00004;
  localparam logic [19:0] B_BA     = 20'h00002;
  localparam logic [19:0] B_COUT   = 20'h00001;
  localparam logic [19:0] F0 = B_PCOUT | B_MARIN | B_INC | B_ZIN;

  int          exp_n;
  logic [19:0] exp_s [8];
  logic [3:0]  exp_a [8];

  task automatic exp_seq(input logic [4:0] opc);
    for (int i = 0; i < 8; i++) begin
      exp_s[i] = '0;
      exp_a[i] = 4'd0;
    end
    exp_s[0] = F0;
    exp_s[1] = B_ZLO | B_PCIN | B_READ | B_MDRIN;
    exp_s[2] = B_MDROUT | B_IRIN;
    exp_n = 3;
    if (opc == 5'd1 || opc == 5'd7 || opc == 5'd0 || opc == 5'd2) begin
      exp_s[3] = B_GRB | B_YIN | ((opc == 5'd7) ? B_ROUT : B_BA);
      exp_s[4] = B_COUT | B_ZIN;
      exp_s[5] = B_ZLO | B_GRA | B_RIN;
      exp_n = 6;
    end
    if (opc >= 5'd3 && opc <= 5'd6) begin
      exp_s[3] = B_GRB | B_ROUT | B_YIN;
      exp_s[4] = B_GRC | B_ROUT | B_ZIN;
      exp_a[4] = 4'(opc - 5'd3);
      exp_s[5] = B_ZLO | B_GRA | B_RIN;
      exp_n = 6;
    end
    if (opc == 5'd0 || opc == 5'd2) begin
      exp_s[5] = B_ZLO | B_MARIN;
      exp_s[6] = (opc == 5'd0) ? (B_READ | B_MDRIN)
                               : (B_GRA | B_ROUT | B_MDRIN);
      exp_s[7] = (opc == 5'd0) ? (B_MDROUT | B_GRA | B_RIN) : B_WRITE;
      exp_n = 8;
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc);
    return {opc, 27'($urandom)};
  endfunction

  // Steps one instruction from T0, comparing every cycle to the table.
  task automatic run_instr(input logic [31:0] ir, input string nm,
                           input int stop_at, input int abort_at,
                           input int wait_k, input int wait_n);
    exp_seq(ir[31:27]);
    IR = ir;
    for (int k = 0; k < exp_n; k++) begin
      if (k == abort_at) begin
        Reset = 1'b1;
        #1;
        n_chk++;
        if (obs !== 20'd0 || alu_op !== 4'd0 || Run !== 1'b0)
          $display("FAIL %s abort: got %h alu=%0d run=%b want 0 0 0",
                   nm, obs, alu_op, Run);
        else n_pass++;
        return;
      end
      n_chk++;
      if (obs !== exp_s[k] || alu_op !== exp_a[k] || Run !== 1'b1)
        $display("FAIL %s step %0d: got %h alu=%0d run=%b want %h alu=%0d run=1",
                 nm, k, obs, alu_op, Run, exp_s[k], exp_a[k]);
      else n_pass++;
      if (k == stop_at) Stop = 1'b1;
`ifdef CTRL_MEMWAIT_EN
      if (k == wait_k && wait_n > 0) begin
        Mem_ready = 1'b0;
        for (int w = 0; w < wait_n; w++) begin
          @(posedge Clock); #1;
          n_chk++;
          if (obs !== exp_s[k] || Run !== 1'b1)
            $display("FAIL %s wait %0d/%0d: got %h run=%b want %h run=1",
                     nm, k, w, obs, Run, exp_s[k]);
          else n_pass++;
        end
        Mem_ready = 1'b1;
      end
`else
      if (wait_k >= 0 && wait_n > 0) Mem_ready = 1'($urandom);
`endif
      @(posedge Clock); #1;
    end
  endtask

  task automatic test_reset();
    IR = 32'h0880_0045;
    Reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock); #1;
      n_chk++;
      if (obs !== 20'd0 || alu_op !== 4'd0 || Run !== 1'b0)
        $display("FAIL reset cyc %0d: got %h alu=%0d run=%b want 0 0 0",
                 c, obs, alu_op, Run);
      else n_pass++;
    end
    Reset = 1'b0;
    #1;
    run_instr(32'h0880_0045, "ldi", -1, -1, -1, 0);
    n_chk++;
    if (obs !== F0 || Run !== 1'b1)
      $display("FAIL ldi_next_t0: got %h run=%b want %h run=1",
               obs, Run, F0);
    else n_pass++;
  endtask

  task automatic test_alu();
    run_instr(mk_ir(OP_ADD), "add", -1, -1, -1, 0);
    run_instr(mk_ir(OP_SUB), "sub", -1, -1, -1, 0);
    run_instr(mk_ir(OP_AND), "and", -1, -1, -1, 0);
    run_instr(mk_ir(OP_OR), "or", -1, -1, -1, 0);
    run_instr(mk_ir(OP_ADDI), "addi", -1, -1, -1, 0);
    n_chk++;
    if (obs !== F0) $display("FAIL alu_next_t0: got %h want %h", obs, F0);
    else n_pass++;
  endtask

  task automatic test_ld_st();
    run_instr(mk_ir(OP_ST), "st", -1, -1, -1, 0);
    run_instr(mk_ir(OP_LD), "ld", -1, -1, -1, 0);
    run_instr(mk_ir(OP_NOP), "nop", -1, -1, -1, 0);
    n_chk++;
    if (obs !== F0) $display("FAIL ldst_next_t0: got %h want %h", obs, F0);
    else n_pass++;
  endtask

`ifdef CTRL_MEMWAIT_EN
  task automatic test_memwait();
    run_instr(mk_ir(OP_LD), "ld_wait", -1, -1, 6, 3);
    run_instr(mk_ir(OP_ST), "st_wait", -1, -1, 7, 2);
    run_instr(mk_ir(OP_ADD), "t1_wait", -1, -1, 1, 2);
    n_chk++;
    if (obs !== F0) $display("FAIL memwait_next_t0: got %h want %h", obs, F0);
    else n_pass++;
  endtask
`endif

  task automatic test_stop();
    run_instr(mk_ir(OP_LD), "ld_stop", 4, -1, -1, 0);
    for (int c = 0; c < 2; c++) begin
      n_chk++;
      if (obs !== 20'd0 || Run !== 1'b0)
        $display("FAIL stopped cyc %0d: got %h run=%b want 0 run=0",
                 c, obs, Run);
      else n_pass++;
      @(posedge Clock); #1;
    end
    Stop = 1'b0;
    @(posedge Clock); #1;
    n_chk++;
    if (obs !== F0 || Run !== 1'b1)
      $display("FAIL stop_release: got %h run=%b want %h run=1", obs, Run, F0);
    else n_pass++;
  endtask

  task automatic test_halt();
    run_instr(mk_ir(OP_HALT), "halt", 0, -1, -1, 0);
    Stop = 1'b0;
    IR = mk_ir(OP_ADD);
    for (int c = 0; c < 3; c++) begin
      n_chk++;
      if (obs !== 20'd0 || alu_op !== 4'd0 || Run !== 1'b0)
        $display("FAIL halted cyc %0d: got %h alu=%0d run=%b want 0 0 0",
                 c, obs, alu_op, Run);
      else n_pass++;
      @(posedge Clock); #1;
    end
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    #1;
    run_instr(mk_ir(OP_ST), "st_abort", -1, 6, -1, 0);
    for (int c = 0; c < 2; c++) begin
      @(posedge Clock); #1;
      n_chk++;
      if (Write !== 1'b0 || obs !== 20'd0 || Run !== 1'b0)
        $display("FAIL abort_hold cyc %0d: got %h write=%b want 0",
                 c, obs, Write);
      else n_pass++;
    end
    Reset = 1'b0;
    #1;
    n_chk++;
    if (obs !== F0 || Run !== 1'b1)
      $display("FAIL abort_restart: got %h run=%b want %h run=1", obs, Run, F0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [4:0] opc;
    int r, st_at, wn;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 10);
      if (r <= 7)       opc = 5'(r);
      else if (r == 8)  opc = OP_NOP;
      else if (r == 9)  opc = 5'($urandom_range(8, 15));
      else              opc = 5'($urandom_range(17, 30));
      st_at = ($urandom_range(0, 3) == 0) ? 0 : -1;
      wn = $urandom_range(0, 2);
      run_instr(mk_ir(opc), "rand", st_at, -1, 1, wn);
      if (st_at == 0) begin
        n_chk++;
        if (obs !== 20'd0 || Run !== 1'b0)
          $display("FAIL rand_stop op %0d: got %h run=%b want 0 run=0",
                   opc, obs, Run);
        else n_pass++;
        Stop = 1'b0;
        @(posedge Clock); #1;
      end
    end
    n_chk++;
    if (obs !== F0) $display("FAIL rand_end: got %h want %h", obs, F0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ld_st();
`ifdef CTRL_MEMWAIT_EN
    test_memwait();
`endif
    test_stop();
    test_halt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
